// File: rtl/lane_encoder_66b_pkg.sv
// ---------------------------------------------------------------------------
// lane_encoder_66b_pkg
//
// Shared constants for the per-lane 64b/66b block encoder:
//   - sync header codes for data and ordered-set blocks
//   - the d_sel code that marks transport-layer data
//   - additive scrambler polynomial taps and per-lane seeds
//   - a helper that advances the scrambler LFSR by one byte
//
// The scrambler items are only referenced when ENC_SCRAMBLER_EN is defined.
// ---------------------------------------------------------------------------
package lane_encoder_66b_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  localparam logic [3:0] DSEL_DATA = 4'h8;

  localparam int unsigned LFSR_W = 23;

  // x^23 + x^21 + x^16 + x^8 + x^5 + x^2 + 1.
  // Bit (n-1) is set for every x^n term, so the feedback bit is the XOR of
  // state bits 22, 20, 15, 7, 4 and 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 23'h508092;

  localparam logic [LFSR_W-1:0] LANE0_SEED = 23'h1DBFBC;
  localparam logic [LFSR_W-1:0] LANE1_SEED = 23'h0607BB;

  typedef struct packed {
    logic [LFSR_W-1:0] state;  // LFSR state after eight shifts
    logic [7:0]        ks;     // keystream byte, first generated bit in [0]
  } lfsr_byte_t;

  // Eight serial LFSR steps. Each feedback bit is both the keystream bit and
  // the new state LSB; the first bit produced lands in the byte LSB so the
  // keystream lines up with payload bit ordering (byte 0 bit 0 first).
  function automatic lfsr_byte_t lfsr_advance_byte(input logic [LFSR_W-1:0] state_in);
    lfsr_byte_t        res;
    logic [LFSR_W-1:0] s;
    logic              fb;
    s      = state_in;
    res.ks = '0;
    for (int i = 0; i < 8; i++) begin
      fb        = ^(s & LFSR_TAPS);
      res.ks[i] = fb;
      s         = {s[LFSR_W-2:0], fb};
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/lane_encoder_66b_lane_scrambler.sv
// ---------------------------------------------------------------------------
// lane_scrambler
//
// Additive (frame-synchronous) scrambler for one lane. The keystream byte
// for the current LFSR state is XORed onto data_in combinationally, so the
// byte accepted on a clock edge is scrambled with the state held before
// that edge; the state then moves on by eight bits.
//
// Parameters:
//   SEED      LFSR load value on reset and on reload
// Ports:
//   clk       byte clock
//   rst       asynchronous active-low reset (loads SEED)
//   advance   step the LFSR by eight bits on this edge
//   reload    load SEED on this edge (wins over advance)
//   data_in   raw byte
//   data_out  data_in XOR keystream byte
// ---------------------------------------------------------------------------
module lane_scrambler
  import lane_encoder_66b_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LANE0_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       reload,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [LFSR_W-1:0] lfsr_q;
  lfsr_byte_t        step;

  assign step     = lfsr_advance_byte(lfsr_q);
  assign data_out = data_in ^ step.ks;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else if (reload) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= step.state;
    end
  end

endmodule

// File: rtl/lane_encoder_66b.sv
// ---------------------------------------------------------------------------
// lane_encoder_66b
//
// Two-lane 64b/66b block encoder on the TX path, fed by the lane
// distributer. Every enabled cycle one byte per lane is collected; after
// eight bytes each lane presents {payload[63:0], sync[1:0]} and enc_valid
// pulses for one cycle. Byte k of a block lands in payload bits [8k+7:8k].
//
// The block class is taken from d_sel on the first byte of a block
// ('h8 = transport data, anything else = ordered set). A class change later
// in the same block raises hdr_err once; the block keeps its first class.
// Dropping enable_enc discards any partial block.
//
// Build option:
//   ENC_SCRAMBLER_EN  adds an additive scrambler per lane; data-block
//                     payloads are scrambled, ordered sets and sync headers
//                     are not. Latency is unchanged.
//
// Ports:
//   clk             byte clock
//   rst             asynchronous active-low reset
//   enable_enc      bytes valid this cycle
//   d_sel[3:0]      block class select
//   lane_0_tx_in    lane 0 byte
//   lane_1_tx_in    lane 1 byte
//   lane_0_enc_out  lane 0 symbol, [1:0] sync, [65:2] payload
//   lane_1_enc_out  lane 1 symbol, same format
//   enc_valid       one-cycle pulse, both symbols updated
//   hdr_err         one-cycle pulse, class changed inside a block
// ---------------------------------------------------------------------------
module lane_encoder_66b
  import lane_encoder_66b_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_enc,
  input  logic [3:0]  d_sel,
  input  logic [7:0]  lane_0_tx_in,
  input  logic [7:0]  lane_1_tx_in,
  output logic [65:0] lane_0_enc_out,
  output logic [65:0] lane_1_enc_out,
  output logic        enc_valid,
  output logic        hdr_err
);

  logic [2:0]  byte_cnt;   // bytes accepted in the current block
  logic        is_data_q;  // class latched on byte 0
  logic        err_seen;   // hdr_err already raised for this block
  logic [55:0] acc_0;      // bytes 0..6 of lane 0; byte 7 goes straight out
  logic [55:0] acc_1;

  logic       d_is_data;
  logic [7:0] lane_0_byte;  // byte to store: scrambled or raw
  logic [7:0] lane_1_byte;

  assign d_is_data = (d_sel == DSEL_DATA);

`ifdef ENC_SCRAMBLER_EN
  logic       class_now;
  logic [7:0] scr_0;
  logic [7:0] scr_1;

  // Both LFSRs run on every accepted byte regardless of class and reseed
  // whenever the distributer is idle.
  lane_scrambler #(.SEED(LANE0_SEED)) u_scr_0 (
    .clk      (clk),
    .rst      (rst),
    .advance  (enable_enc),
    .reload   (!enable_enc),
    .data_in  (lane_0_tx_in),
    .data_out (scr_0)
  );

  lane_scrambler #(.SEED(LANE1_SEED)) u_scr_1 (
    .clk      (clk),
    .rst      (rst),
    .advance  (enable_enc),
    .reload   (!enable_enc),
    .data_in  (lane_1_tx_in),
    .data_out (scr_1)
  );

  // On byte 0 the class register is not loaded yet, so use d_sel directly.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    class_now   = is_data_q;
    lane_0_byte = lane_0_tx_in;
    lane_1_byte = lane_1_tx_in;
    if (byte_cnt == 3'd0) begin
      class_now = d_is_data;
    end
    if (class_now) begin
      lane_0_byte = scr_0;
      lane_1_byte = scr_1;
    end
  end
`else
  assign lane_0_byte = lane_0_tx_in;
  assign lane_1_byte = lane_1_tx_in;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the collectors are a handful of flops, not a RAM, so they are
  // reset along with everything else and no stale bytes survive a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt       <= '0;
      is_data_q      <= 1'b0;
      err_seen       <= 1'b0;
      acc_0          <= '0;
      acc_1          <= '0;
      lane_0_enc_out <= '0;
      lane_1_enc_out <= '0;
      enc_valid      <= 1'b0;
      hdr_err        <= 1'b0;
    end else begin
      enc_valid <= 1'b0;
      hdr_err   <= 1'b0;

      if (!enable_enc) begin
        // Abandon any partial block; outputs keep the last full symbols.
        byte_cnt <= '0;
        err_seen <= 1'b0;
      end else begin
        byte_cnt <= byte_cnt + 3'd1;

        if (byte_cnt == 3'd0) begin
          is_data_q <= d_is_data;
          err_seen  <= 1'b0;
        end else if ((is_data_q != d_is_data) && !err_seen) begin
          hdr_err  <= 1'b1;
          err_seen <= 1'b1;
        end

        for (int k = 0; k < 7; k++) begin
          if (byte_cnt == 3'(k)) begin
            acc_0[8*k +: 8] <= lane_0_byte;
            acc_1[8*k +: 8] <= lane_1_byte;
          end
        end

        if (byte_cnt == 3'd7) begin
          lane_0_enc_out <= {lane_0_byte, acc_0, (is_data_q ? SYNC_DATA : SYNC_OS)};
          lane_1_enc_out <= {lane_1_byte, acc_1, (is_data_q ? SYNC_DATA : SYNC_OS)};
          enc_valid      <= 1'b1;
        end
      end
    end
  end

endmodule
